// File: rtl/df_signal_generator.sv
// -----------------------------------------------------------------------------
// df_signal_generator
// Generates one test waveform (rect, triangle, sine or dirac) as an 8-bit
// sample stream for a downstream filter, and issues single filter
// configuration writes.
//
// Ports
//   clk         : clock, all registers update on the rising edge
//   rst         : asynchronous active-high reset
//   start       : run one waveform (sampled in IDLE only)
//   wave_sel    : 00 rect, 01 triangle, 10 sine, 11 dirac
//   half_presc  : half-period h in clocks (0 behaves as 1)
//   cfg_req     : issue one configuration write (sampled in IDLE only, wins over start)
//   cfg_hp      : highpass bit  -> configout[2]
//   cfg_wg      : cutoff code   -> configout[1:0]
//   dataout     : registered sample stream
//   enconfig    : configuration strobe (CFG_EN only)
//   configout   : configuration word {hp, wg} during CFG_EN, else 000
//   busy        : high outside IDLE
//   done        : one-cycle pulse in FIN
// -----------------------------------------------------------------------------
module df_signal_generator #(
   parameter int unsigned CYCLES_PER_SIGNAL = 250,
   parameter logic [7:0]  MIN_VAL           = 8'h00,
   parameter logic [7:0]  MAX_VAL           = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] wave_sel,
   input  logic [6:0] half_presc,
   input  logic       cfg_req,
   input  logic       cfg_hp,
   input  logic [1:0] cfg_wg,
   output logic [7:0] dataout,
   output logic       enconfig,
   output logic [2:0] configout,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CFG_PRE, ST_CFG_EN, ST_CFG_POST, ST_PREP, ST_RUN, ST_FIN
   } state_t;

   localparam logic [1:0] WAVE_RECT  = 2'b00;
   localparam logic [1:0] WAVE_TRI   = 2'b01;
   localparam logic [1:0] WAVE_SINE  = 2'b10;
   localparam logic [1:0] WAVE_DIRAC = 2'b11;

   // Wide enough for elapsed + 1 + 2h without overflow.
   localparam int unsigned   CNT_W   = $clog2(CYCLES_PER_SIGNAL + 512);
   localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(CYCLES_PER_SIGNAL);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIRAC_POS = CNT_W'(9);

   // First quadrant of S(p) = floor(127.5 * (1 + sin(2*pi*p/256))), p = 0..64.
   function automatic logic [7:0] sine_quarter(input logic [6:0] k);
      case (k)
         7'd0:  return 8'd127;  7'd1:  return 8'd130;  7'd2:  return 8'd133;  7'd3:  return 8'd136;
         7'd4:  return 8'd139;  7'd5:  return 8'd143;  7'd6:  return 8'd146;  7'd7:  return 8'd149;
         7'd8:  return 8'd152;  7'd9:  return 8'd155;  7'd10: return 8'd158;  7'd11: return 8'd161;
         7'd12: return 8'd164;  7'd13: return 8'd167;  7'd14: return 8'd170;  7'd15: return 8'd173;
         7'd16: return 8'd176;  7'd17: return 8'd179;  7'd18: return 8'd182;  7'd19: return 8'd184;
         7'd20: return 8'd187;  7'd21: return 8'd190;  7'd22: return 8'd193;  7'd23: return 8'd195;
         7'd24: return 8'd198;  7'd25: return 8'd200;  7'd26: return 8'd203;  7'd27: return 8'd205;
         7'd28: return 8'd208;  7'd29: return 8'd210;  7'd30: return 8'd213;  7'd31: return 8'd215;
         7'd32: return 8'd217;  7'd33: return 8'd219;  7'd34: return 8'd221;  7'd35: return 8'd224;
         7'd36: return 8'd226;  7'd37: return 8'd228;  7'd38: return 8'd229;  7'd39: return 8'd231;
         7'd40: return 8'd233;  7'd41: return 8'd235;  7'd42: return 8'd236;  7'd43: return 8'd238;
         7'd44: return 8'd239;  7'd45: return 8'd241;  7'd46: return 8'd242;  7'd47: return 8'd244;
         7'd48: return 8'd245;  7'd49: return 8'd246;  7'd50: return 8'd247;  7'd51: return 8'd248;
         7'd52: return 8'd249;  7'd53: return 8'd250;  7'd54: return 8'd251;  7'd55: return 8'd251;
         7'd56: return 8'd252;  7'd57: return 8'd253;  7'd58: return 8'd253;  7'd59: return 8'd254;
         7'd60: return 8'd254;  7'd61: return 8'd254;  7'd62: return 8'd254;  7'd63: return 8'd254;
         default: return 8'd255;
      endcase
   endfunction

   // Full table by symmetry. For the lower half floor(x)+floor(255-x) = 254
   // whenever x is non-integer, which holds everywhere except the peak.
   function automatic logic [7:0] sine_sample(input logic [7:0] p);
      logic [7:0] q;
      logic [7:0] k;
      logic [7:0] upper;
      q     = {1'b0, p[6:0]};
      k     = (q <= 8'd64) ? q : (8'd128 - q);
      upper = sine_quarter(k[6:0]);
      if (!p[7])
         return upper;
      else if (q == 8'd64)
         return 8'd0;
      else
         return 8'd254 - upper;
   endfunction

   state_t           state_reg, state_next;
   logic [1:0]       wave_reg, wave_next;
   logic [6:0]       h_reg, h_next;
   logic [2:0]       cfg_word_reg, cfg_word_next;
   logic [2:0]       prep_cnt_reg, prep_cnt_next;
   logic [7:0]       div_q_reg, div_q_next;     // dividend, becomes Q after 8 steps
   logic [7:0]       div_r_reg, div_r_next;     // partial remainder, becomes R
   logic [7:0]       pos_reg, pos_next;         // position inside the current period
   logic [7:0]       y_reg, y_next;             // DDA integer part (value or sine phase)
   logic [7:0]       rem_reg, rem_next;         // DDA fractional numerator, 0..h-1
   logic [CNT_W-1:0] elapsed_reg, elapsed_next; // samples emitted so far
   logic [7:0]       dataout_reg, dataout_next;

   logic [7:0]       h8, h2, div_shift, sample_next;
   logic [8:0]       up_sum;
   logic [CNT_W-1:0] h2_cnt;
   logic             no_periods, run_end;

   assign h8     = {1'b0, h_reg};
   assign h2     = {h_reg, 1'b0};
   assign h2_cnt = CNT_W'(h2);
   assign no_periods = (wave_reg != WAVE_DIRAC) && (h2_cnt > N_CNT);

   // Last sample of the run: dirac after N samples, periodic waves when the
   // next whole period would overrun N.
   always_comb begin
      if (wave_reg == WAVE_DIRAC)
         run_end = (elapsed_reg == N_CNT - ONE_CNT);
      else
         run_end = (pos_reg == h2 - 8'd1) && ((elapsed_reg + ONE_CNT + h2_cnt) > N_CNT);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:     if (cfg_req) state_next = ST_CFG_PRE;
                      else if (start) state_next = ST_PREP;
         ST_CFG_PRE:  state_next = ST_CFG_EN;
         ST_CFG_EN:   state_next = ST_CFG_POST;
         ST_CFG_POST: state_next = ST_IDLE;
         ST_PREP:     if (prep_cnt_reg == 3'd7) state_next = no_periods ? ST_FIN : ST_RUN;
         ST_RUN:      if (run_end) state_next = ST_FIN;
         ST_FIN:      state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy      = (state_reg != ST_IDLE);
      done      = (state_reg == ST_FIN);
      enconfig  = (state_reg == ST_CFG_EN);
      configout = (state_reg == ST_CFG_EN) ? cfg_word_reg : 3'b000;
   end
   assign dataout = dataout_reg;

   // Datapath: capture, restoring divider, DDA
   always_comb begin
      wave_next     = wave_reg;
      h_next        = h_reg;
      cfg_word_next = cfg_word_reg;
      prep_cnt_next = prep_cnt_reg;
      div_q_next    = div_q_reg;
      div_r_next    = div_r_reg;
      pos_next      = pos_reg;
      y_next        = y_reg;
      rem_next      = rem_reg;
      elapsed_next  = elapsed_reg;
      div_shift     = {div_r_reg[6:0], div_q_reg[7]};
      up_sum        = {1'b0, rem_reg} + {1'b0, div_r_reg};
      case (state_reg)
         ST_IDLE: begin
            if (cfg_req) begin
               cfg_word_next = {cfg_hp, cfg_wg};
            end else if (start) begin
               wave_next     = wave_sel;
               h_next        = (half_presc == 7'd0) ? 7'd1 : half_presc;
               prep_cnt_next = 3'd0;
               div_r_next    = 8'd0;
               div_q_next    = (wave_sel == WAVE_TRI)  ? 8'd255 :
                               (wave_sel == WAVE_SINE) ? 8'd128 : 8'd0;
            end
         end
         ST_PREP: begin
            // Remainder stays below h <= 127, so the shift never loses a bit.
            if (div_shift >= h8) begin
               div_r_next = div_shift - h8;
               div_q_next = {div_q_reg[6:0], 1'b1};
            end else begin
               div_r_next = div_shift;
               div_q_next = {div_q_reg[6:0], 1'b0};
            end
            prep_cnt_next = prep_cnt_reg + 3'd1;
            pos_next      = 8'd0;
            y_next        = 8'd0;
            rem_next      = 8'd0;
            elapsed_next  = '0;
         end
         ST_RUN: begin
            elapsed_next = elapsed_reg + ONE_CNT;
            if (wave_reg != WAVE_DIRAC) begin
               if (pos_reg == h2 - 8'd1) begin
                  pos_next = 8'd0;
                  y_next   = 8'd0;
                  rem_next = 8'd0;
               end else begin
                  pos_next = pos_reg + 8'd1;
                  if ((wave_reg == WAVE_TRI) && (pos_next > h8)) begin
                     // Falling half: subtract Q + R/h with borrow.
                     if (rem_reg < div_r_reg) begin
                        rem_next = rem_reg + h8 - div_r_reg;
                        y_next   = y_reg - div_q_reg - 8'd1;
                     end else begin
                        rem_next = rem_reg - div_r_reg;
                        y_next   = y_reg - div_q_reg;
                     end
                  end else begin
                     // Rising half / sine phase: add Q + R/h with carry.
                     if (up_sum >= {1'b0, h8}) begin
                        rem_next = up_sum[7:0] - h8;
                        y_next   = y_reg + div_q_reg + 8'd1;
                     end else begin
                        rem_next = up_sum[7:0];
                        y_next   = y_reg + div_q_reg;
                     end
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Sample for the coming cycle, registered into dataout.
   always_comb begin
      case (wave_reg)
         WAVE_RECT: sample_next = (pos_next < h8) ? MIN_VAL : MAX_VAL;
         WAVE_TRI:  sample_next = y_next;
         WAVE_SINE: sample_next = sine_sample(y_next);
         default:   sample_next = (elapsed_next == DIRAC_POS) ? MAX_VAL : MIN_VAL;
      endcase
      dataout_next = (state_next == ST_RUN) ? sample_next : MIN_VAL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wave_reg     <= 2'b00;
         h_reg        <= 7'd0;
         cfg_word_reg <= 3'b000;
         prep_cnt_reg <= 3'd0;
         div_q_reg    <= 8'd0;
         div_r_reg    <= 8'd0;
         pos_reg      <= 8'd0;
         y_reg        <= 8'd0;
         rem_reg      <= 8'd0;
         elapsed_reg  <= '0;
         dataout_reg  <= MIN_VAL;
      end else begin
         wave_reg     <= wave_next;
         h_reg        <= h_next;
         cfg_word_reg <= cfg_word_next;
         prep_cnt_reg <= prep_cnt_next;
         div_q_reg    <= div_q_next;
         div_r_reg    <= div_r_next;
         pos_reg      <= pos_next;
         y_reg        <= y_next;
         rem_reg      <= rem_next;
         elapsed_reg  <= elapsed_next;
         dataout_reg  <= dataout_next;
      end
   end

endmodule

// File: tb/tb_df_signal_generator.sv
module tb_df_signal_generator;

   localparam int N = 250;
   localparam logic [7:0] MINV = 8'h00;
   localparam logic [7:0] MAXV = 8'hFF;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] wave_sel;
   logic [6:0] half_presc;
   logic       cfg_req;
   logic       cfg_hp;
   logic [1:0] cfg_wg;
   logic [7:0] dataout;
   logic       enconfig;
   logic [2:0] configout;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   df_signal_generator #(
      .CYCLES_PER_SIGNAL(N),
      .MIN_VAL(MINV),
      .MAX_VAL(MAXV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .wave_sel(wave_sel),
      .half_presc(half_presc),
      .cfg_req(cfg_req),
      .cfg_hp(cfg_hp),
      .cfg_wg(cfg_wg),
      .dataout(dataout),
      .enconfig(enconfig),
      .configout(configout),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference sine sample; the tiny offset keeps sin(pi/2) from rounding below 255.
   function automatic logic [7:0] sine_ref(input int p);
      real s;
      s = $sin(2.0 * 3.14159265358979 * p / 256.0);
      return 8'($rtoi($floor(255.0 * (s + 1.0) / 2.0 + 1.0e-9)));
   endfunction

   // Builds the expected stream, starts the run, then checks PREP length,
   // every sample, the done pulse and the return to IDLE.
   task automatic run_wave(input logic [1:0] ws, input logic [6:0] hp, input bit inject);
      int hh;
      int periods;
      int idx;
      logic [7:0] e;
      hh = (hp == 0) ? 1 : int'(hp);
      exp_q.delete();
      if (ws == 2'b11) begin
         for (int i = 0; i < N; i++) exp_q.push_back((i == 9) ? MAXV : MINV);
      end else begin
         periods = N / (2 * hh);
         for (int p = 0; p < periods; p++) begin
            for (int j = 0; j < 2 * hh; j++) begin
               case (ws)
                  2'b00:   e = (j < hh) ? MINV : MAXV;
                  2'b01:   e = (j < hh) ? 8'((255 * j) / hh) : 8'((255 * (2 * hh - j)) / hh);
                  default: e = sine_ref((128 * j) / hh);
               endcase
               exp_q.push_back(e);
            end
         end
      end
      $display("run wave=%0d h=%0d expected_samples=%0d", ws, hp, exp_q.size());
      start = 1'b1; wave_sel = ws; half_presc = hp;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("prep_busy", busy, 1);
         check("prep_dataout", dataout, MINV);
         @(negedge clk);
      end
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sample", dataout, e);
         check("run_done_low", done, 0);
         if (inject) begin
            check("inject_enconfig", enconfig, 0);
            if (idx == 100) begin
               start = 1'b1; cfg_req = 1'b1; cfg_hp = 1'b1; cfg_wg = 2'b11; wave_sel = 2'b00;
            end else if (idx == 101) begin
               start = 1'b0; cfg_req = 1'b0;
            end
         end
         idx++;
         @(negedge clk);
      end
      check("fin_done", done, 1);
      check("fin_dataout", dataout, MINV);
      check("fin_busy", busy, 1);
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; wave_sel = 2'b00; half_presc = 7'd0;
      cfg_req = 1'b0; cfg_hp = 1'b0; cfg_wg = 2'b00;
      repeat (2) @(negedge clk);
      check("rst_dataout", dataout, MINV);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_enconfig", enconfig, 0);
      check("rst_configout", configout, 3'b000);
      rst = 1'b0;
      @(negedge clk);

      // Configuration write, with a simultaneous start that must be dropped.
      cfg_req = 1'b1; cfg_hp = 1'b1; cfg_wg = 2'b11; start = 1'b1; wave_sel = 2'b01;
      @(negedge clk);
      cfg_req = 1'b0; start = 1'b0; cfg_hp = 1'b0; cfg_wg = 2'b00;
      check("cfg_pre_en", enconfig, 0);
      check("cfg_pre_word", configout, 3'b000);
      check("cfg_pre_busy", busy, 1);
      @(negedge clk);
      check("cfg_en_en", enconfig, 1);
      check("cfg_en_word", configout, 3'b111);
      check("cfg_en_busy", busy, 1);
      @(negedge clk);
      check("cfg_post_en", enconfig, 0);
      check("cfg_post_word", configout, 3'b000);
      check("cfg_post_busy", busy, 1);
      @(negedge clk);
      check("cfg_idle_busy", busy, 0);
      check("cfg_start_dropped", dataout, MINV);
      $display("cfg write hp=1 wg=3 done");

      run_wave(2'b00, 7'd25, 1'b0);
      run_wave(2'b00, 7'd0, 1'b0);
      run_wave(2'b01, 7'd2, 1'b0);
      run_wave(2'b01, 7'd3, 1'b0);
      run_wave(2'b10, 7'd2, 1'b0);
      run_wave(2'b10, 7'd5, 1'b0);
      run_wave(2'b10, 7'd126, 1'b0);
      run_wave(2'b11, 7'd4, 1'b1);

      // Asynchronous reset in the middle of a triangle run (h=10).
      start = 1'b1; wave_sel = 2'b01; half_presc = 7'd10;
      @(negedge clk);
      start = 1'b0;
      repeat (23) @(negedge clk);
      check("pre_rst_sample", dataout, (255 * 5) / 10);
      #2 rst = 1'b1;
      #1;
      check("async_rst_dataout", dataout, MINV);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      @(negedge clk);
      check("rst_hold_done", done, 0);
      check("rst_hold_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
      $display("async reset during triangle run");

      run_wave(2'b01, 7'd7, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/df_signal_generator.md
DF_SIGNAL_GENERATOR -- requirements
Module: df_signal_generator

Interface
REQ-001 Parameter CYCLES_PER_SIGNAL, default 250, sets the sample budget N of one waveform.
REQ-002 Parameter MIN_VAL, default 8'h00, is the low output level.
REQ-003 Parameter MAX_VAL, default 8'hFF, is the high output level.
REQ-004 CLK  in  1  single clock; every register is updated on the rising edge.
REQ-005 RST  in  1  asynchronous reset, active-high.
REQ-006 start  in  1  request to run one waveform; sampled only in IDLE.
REQ-007 wave_sel  in  2  waveform select: 00 rect, 01 triangle, 10 sine, 11 dirac.
REQ-008 half_presc  in  7  half-period h in clocks; 0 is treated as 1.
REQ-009 cfg_req  in  1  request to issue one filter configuration write; sampled only in IDLE.
REQ-010 cfg_hp  in  1  highpass bit sent on configout[2].
REQ-011 cfg_wg  in  2  cutoff code sent on configout[1:0].
REQ-012 dataout  out  8  registered sample stream, which drives the filter data input.
REQ-013 enconfig  out  1  configuration strobe to the filter.
REQ-014 configout  out  3  configuration word {hp, wg1, wg0}.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at the end of a waveform.

Function
REQ-017 The FSM shall have these states: IDLE, CFG_PRE, CFG_EN, CFG_POST, PREP, RUN, FIN.
REQ-018 In IDLE, cfg_req=1 shall capture cfg_hp and cfg_wg and go to CFG_PRE; it takes priority over a simultaneous start, and that start is dropped.
REQ-019 CFG_PRE, CFG_EN and CFG_POST shall each last 1 clock, after which the FSM returns to IDLE.
REQ-020 enconfig shall be 1 only in CFG_EN, with configout equal to the captured word; in every other state configout shall be 3'b000.
REQ-021 In IDLE, start=1 with cfg_req=0 shall capture wave_sel and h, then enter PREP.
REQ-022 start and cfg_req asserted while busy shall be ignored.
REQ-023 PREP shall last exactly 8 clocks. It runs a restoring divider that computes Q = D div h and R = D mod h, with D = 255 for triangle and D = 128 for sine; PREP takes 8 clocks for every waveform type.
REQ-024 RUN shall emit one sample per clock, and sample 0 shall be visible on dataout in the first clock after PREP.
REQ-025 Rect: each period shall be h samples of MIN_VAL followed by h samples of MAX_VAL.
REQ-026 Triangle rising half: samples j = 0..h-1 shall equal floor(255*j/h), produced by an up-DDA (rem += R; if rem >= h then rem -= h and y += Q+1, else y += Q).
REQ-027 Triangle falling half: samples j = h..1 shall equal floor(255*j/h), produced by the matching down-DDA with borrow, starting from y = 255 and rem = 0.
REQ-028 Sine: for j = 0..2h-1, phase p = floor(128*j/h) (8 bits) shall be produced by the DDA, and the sample shall be S(p) = floor(255*(sin(2*pi*p/256)+1)/2); the lookup table shall match S exactly.
REQ-029 Dirac: 9 samples of MIN_VAL, then 1 sample of MAX_VAL, then N-10 samples of MIN_VAL, for N samples in total.
REQ-030 Rect, triangle and sine shall run only whole periods. At each period boundary, if elapsed + 2h > N the run ends, so the number of periods is floor(N/(2h)).
REQ-031 When zero periods fit (h > N/2), RUN shall emit no samples and the FSM shall go directly from PREP to FIN.
REQ-032 FIN shall last 1 clock with done=1 and dataout=MIN_VAL, then go to IDLE.
REQ-033 dataout shall be MIN_VAL outside RUN.
REQ-034 All arithmetic shall be unsigned, and the DDA accumulators shall never leave the range 0..255.

Reset
REQ-035 While RST=1: dataout=MIN_VAL, enconfig=0, configout=000, busy=0, done=0, FSM=IDLE, and all counters and accumulators = 0.
REQ-036 RST asserted mid-operation shall abort immediately with no done pulse.
REQ-037 After RST deasserts, operation shall resume from IDLE on the next rising edge of CLK.

Verification
REQ-038 Reset: pulse RST during a triangle run -> outputs go to the reset values without waiting for a clock edge; busy=0; no done pulse.
REQ-039 cfg_req with hp=1, wg=11 -> enconfig=1 for exactly 1 clock, 2 clocks after acceptance; configout=111 only in that clock; busy high for 3 clocks.
REQ-040 Rect with h=25 -> 5 periods, each 25x00 then 25xFF (250 samples), then FIN with done pulse; h=0 behaves as h=1 (125 periods of 00, FF).
REQ-041 Triangle with h=2 -> 00,7F,FF,7F repeated 62 times (248 samples); h=3 -> 00,55,AA,FF,AA,55 repeated 41 times.
REQ-042 Sine with h=2 -> phases 0,64,128,192 -> 7F,FF,7F,00 repeated 62 times; h=126 -> no samples, done 9 clocks after start.
REQ-043 Dirac -> 9x00, 1xFF, 240x00, then done; start and cfg_req asserted during RUN are ignored with no change to the output stream.
